// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller.
//
// Walks IDLE -> REQ -> WAIT -> HOLD. It issues one request at the current
// PC, waits for the response, then presents the instruction to decode until
// decode accepts it (stall low). A redirect reloads the PC from any state
// except IDLE. A response that was already requested when the redirect
// arrived is dropped through the kill flag.
//
// Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target fetches from TRAP_VEC and
//               pulses trap_valid for one cycle.
//   undefined : a misaligned redirect target is force-aligned and
//               trap_valid stays 0.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous reset, active low
//   imem_req       out  fetch request (high in REQ)
//   imem_addr      out  fetch address (= PC)
//   imem_gnt       in   request accepted by memory
//   imem_rvalid    in   response valid
//   imem_rdata     in   response instruction word
//   stall          in   decode back-pressure (holds the presented instruction)
//   redirect_valid in   branch/jump redirect strobe
//   redirect_pc    in   redirect target
//   if_valid       out  if_instr/if_pc valid for decode
//   if_instr       out  fetched instruction (registered)
//   if_pc          out  address of if_instr (registered)
//   trap_valid     out  misaligned-redirect trap pulse (registered)
module fetch_ctrl #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0]      TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            trap_valid
);

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            trap_q, trap_d;
  logic            misaligned_s;
  logic [XLEN-1:0] redir_target_s;

  // Redirect target selection; trap vector replaces misaligned targets only when trapping is built in.
  always_comb begin
    misaligned_s = (redirect_pc[1:0] != 2'b00);
    if (TRAP_EN && misaligned_s) begin
      redir_target_s = TRAP_VEC;
    end else begin
      redir_target_s = {redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  // State register and all datapath flops, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0000_0000;
      if_pc_q    <= {XLEN{1'b0}};
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      trap_q     <= trap_d;
    end
  end

  // Next-state and next-datapath logic; redirect outranks everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    trap_d     = 1'b0;

    if ((state_q != ST_IDLE) && redirect_valid) begin
      trap_d = TRAP_EN & misaligned_s;
    end else begin
      trap_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_target_s;
          if (imem_gnt) begin
            // The accepted request is for the old PC: its response must be dropped.
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end else if (imem_gnt) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_target_s;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_STEP;
            state_d    = ST_HOLD;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d       = redir_target_s;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (!stall) begin
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        kill_d     = 1'b0;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // Output decode from the registered state and flops.
  always_comb begin
    imem_req   = (state_q == ST_REQ);
    imem_addr  = pc_q;
    if_valid   = if_valid_q;
    if_instr   = if_instr_q;
    if_pc      = if_pc_q;
    trap_valid = trap_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        trap_valid;

  int n_checks;
  int n_fail;

  fetch_ctrl #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .trap_valid    (trap_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_redir;
    logic        exp_trap;
    n_checks = 0;
    n_fail   = 0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    exp_redir = 32'h0000_0100;
    exp_trap  = 1'b1;
`else
    exp_redir = 32'h0000_0200;
    exp_trap  = 1'b0;
`endif

    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_valid", {31'd0, if_valid},   32'd0);
    chk("rst_instr", if_instr,            32'h0);
    chk("rst_pc",    if_pc,               32'h0);
    chk("rst_trap",  {31'd0, trap_valid}, 32'd0);

    // release: IDLE one cycle, then REQ/WAIT/HOLD per fetch
    reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    chk("f0_req",  {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr,         32'h0);
    step();
    chk("f0_wait_req", {31'd0, imem_req}, 32'd0);
    chk("f0_wait_vld", {31'd0, if_valid}, 32'd0);
    step();
    chk("f0_valid", {31'd0, if_valid}, 32'd1);
    chk("f0_instr", if_instr,          32'h0000_0013);
    chk("f0_pc",    if_pc,             32'h0);
    imem_rdata = 32'h0010_0093;
    step();
    chk("f1_vld_clr", {31'd0, if_valid}, 32'd0);
    chk("f1_addr",    imem_addr,         32'h4);
    step(); step();
    chk("f1_valid", {31'd0, if_valid}, 32'd1);
    chk("f1_pc",    if_pc,             32'h4);
    chk("f1_instr", if_instr,          32'h0010_0093);
    imem_rdata = 32'h0020_0113;
    step();
    chk("f2_addr", imem_addr, 32'h8);
    step(); step();
    chk("f2_pc", if_pc, 32'h8);

    // stall for 5 cycles in HOLD
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc",    if_pc,             32'h8);
      chk("stall_instr", if_instr,          32'h0020_0113);
      chk("stall_req",   {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0; imem_rvalid = 1'b0;
    step();
    chk("unstall_req",  {31'd0, imem_req}, 32'd1);
    chk("unstall_addr", imem_addr,         32'hC);
    chk("unstall_vld",  {31'd0, if_valid}, 32'd0);

    // redirect during WAIT: in-flight response dropped
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    chk("kill_vld", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("kill_drop_vld", {31'd0, if_valid}, 32'd0);
    chk("kill_req",      {31'd0, imem_req}, 32'd1);
    chk("kill_addr",     imem_addr,         32'h0000_0200);
    chk("kill_pc_kept",  if_pc,             32'h8);
    imem_rdata = 32'h00A0_0093;
    step(); step();
    chk("post_kill_pc",    if_pc,    32'h0000_0200);
    chk("post_kill_instr", if_instr, 32'h00A0_0093);

    // misaligned redirect in HOLD, with stall high
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202; stall = 1'b1;
    step();
    chk("mis_vld",  {31'd0, if_valid},   32'd0);
    chk("mis_addr", imem_addr,           exp_redir);
    chk("mis_trap", {31'd0, trap_valid}, {31'd0, exp_trap});
    redirect_valid = 1'b0; stall = 1'b0; imem_gnt = 1'b0;
    step();
    chk("mis_trap_clr", {31'd0, trap_valid}, 32'd0);
    chk("mis_hold_req", {31'd0, imem_req},   32'd1);

    // redirect in REQ without gnt, then wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr", imem_addr,         32'hFFFF_FFFC);
    chk("wrap_req",  {31'd0, imem_req}, 32'd1);
    redirect_valid = 1'b0; imem_gnt = 1'b1; imem_rdata = 32'h0000_0013;
    step(); step();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_next", imem_addr, 32'h0);

    // redirect in WAIT with rvalid in the same cycle
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    chk("same_vld",  {31'd0, if_valid}, 32'd0);
    chk("same_addr", imem_addr,         32'h0000_0300);
    chk("same_pc",   if_pc,             32'hFFFF_FFFC);

    // redirect in REQ with gnt: kill, then dropped
    redirect_pc = 32'h0000_0500; imem_rvalid = 1'b0;
    step();
    redirect_valid = 1'b0; imem_rvalid = 1'b1;
    step();
    chk("reqk_vld",  {31'd0, if_valid}, 32'd0);
    chk("reqk_addr", imem_addr,         32'h0000_0500);

    // reset in WAIT, late rvalid during IDLE, redirect ignored in IDLE
    imem_rvalid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("mid_rst_req",   {31'd0, imem_req}, 32'd0);
    chk("mid_rst_addr",  imem_addr,         32'h0);
    chk("mid_rst_instr", if_instr,          32'h0);
    reset = 1'b1; imem_rvalid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    step();
    chk("late_vld",  {31'd0, if_valid}, 32'd0);
    chk("late_req",  {31'd0, imem_req}, 32'd1);
    chk("late_addr", imem_addr,         32'h0);
    redirect_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
